// File: rtl/latch_bank_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : latch_bank_writer_if
//  Purpose  : Write-request handshake bundle for latch_bank_writer.
//             master drives valid/addr/data, slave returns ready.
//  Signals  : in_valid  - write request valid
//             in_ready  - controller can accept a request
//             in_addr   - target latch word
//             in_data   - word to write
//  Revision : 1.0 - initial release
// ============================================================================
interface latch_bank_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;

    modport master (
        output in_valid,
        output in_addr,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_data,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/latch_bank_writer.sv
`default_nettype none
// ============================================================================
//  Module   : latch_bank_writer
//  Purpose  : Write controller for a bank of level-sensitive D latches.
//             Accepts a word over valid/ready, puts it on the shared latch
//             data bus, then issues a one-hot enable pulse framed by a data
//             setup and hold window. A shadow register file mirrors every
//             written word since the latch bank itself cannot be read.
//  Ports    : clk      - system clock, rising edge
//             rst      - asynchronous active-high reset
//             req      - write request handshake (slave side)
//             lat_d    - shared latch data bus
//             lat_en   - one-hot latch enables, bit i -> latch word i
//             busy     - write sequence in progress
//             done     - one-cycle pulse in the final HOLD cycle
//             rd_addr  - shadow readback address
//             rd_data  - shadow value at rd_addr (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module latch_bank_writer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    latch_bank_writer_if.slave          req,
    output logic [DATA_W-1:0]           lat_d,
    output logic [(2**ADDR_W)-1:0]      lat_en,
    output logic                        busy,
    output logic                        done,
    input  wire logic [ADDR_W-1:0]      rd_addr,
    output logic [DATA_W-1:0]           rd_data
);

    localparam int NUM_LATCH = 2 ** ADDR_W;

    // Phase counter only ever holds (phase length - 1), so it needs
    // clog2 of the longest phase, with a floor of one bit.
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]     c_setup_ld = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]     c_pulse_ld = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]     c_hold_ld  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]     c_cnt_one  = CNT_W'(1);
    localparam logic [NUM_LATCH-1:0] c_en_one   = NUM_LATCH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_data;
    logic [DATA_W-1:0]    r_lat_d;
    logic [NUM_LATCH-1:0] r_lat_en;
    logic                 r_done;
    logic [DATA_W-1:0]    r_shadow [NUM_LATCH];

    // Ready is masked by rst so nothing is advertised while reset is held.
    assign req.in_ready = (r_state == ST_IDLE) && !rst;
    assign busy         = (r_state != ST_IDLE);
    assign lat_d        = r_lat_d;
    assign lat_en       = r_lat_en;
    assign done         = r_done;
    assign rd_data      = r_shadow[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_lat_d  <= '0;
            r_lat_en <= '0;
            r_done   <= 1'b0;
            for (int i = 0; i < NUM_LATCH; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_lat_en <= '0;
                    r_done   <= 1'b0;
                    // in_ready is high whenever we are here out of reset
                    if (req.in_valid) begin
                        r_addr  <= req.in_addr;
                        r_data  <= req.in_data;
                        r_lat_d <= req.in_data;
                        r_cnt   <= c_setup_ld;
                        r_state <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        // Enable is registered so it rises cleanly on the
                        // same edge the FSM enters PULSE.
                        r_lat_en <= c_en_one << r_addr;
                        r_cnt    <= c_pulse_ld;
                        r_state  <= ST_PULSE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_lat_en         <= '0;
                        r_shadow[r_addr] <= r_data;
                        r_cnt            <= c_hold_ld;
                        r_state          <= ST_HOLD;
                        // done marks the HOLD cycle whose count is 0; with a
                        // single hold cycle that is the very first one.
                        r_done           <= (HOLD_CYC == 1);
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        // Count is about to reach 0: raise done for that cycle
                        r_done <= (r_cnt == c_cnt_one);
                        r_cnt  <= r_cnt - c_cnt_one;
                    end
                end

                default: begin
                    r_lat_en <= '0;
                    r_done   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/latch_bank_writer.md
# latch_bank_writer

Synchronous write controller that drives a bank of level-sensitive D latches, such as the NOR-gate D-latch cell. It accepts words over a valid/ready handshake and presents the data on a shared latch data bus. It then generates a one-hot, fixed-width enable pulse with guaranteed data setup and hold around it. A shadow register file mirrors every value written, because the latch bank has no read path.

## Interface

- DATA_W, 8, width of latch data bus and write data
- ADDR_W, 2, latch address width; NUM_LATCH = 2**ADDR_W latch words
- SETUP_CYC, 1, cycles lat_d is stable before enable rises (≥1)
- PULSE_CYC, 2, cycles enable is held high (≥1)
- HOLD_CYC, 1, cycles lat_d is held after enable falls (≥1)

- clk  in  1  system clock, rising-edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  write request valid
- in_ready  out  1  controller can accept a request
- in_addr  in  ADDR_W  target latch word
- in_data  in  DATA_W  word to write
- lat_d  out  DATA_W  shared data bus to all latch d inputs
- lat_en  out  NUM_LATCH  one-hot latch enables; bit i drives the en of word i
- busy  out  1  write sequence in progress
- done  out  1  one-cycle pulse marking the final HOLD cycle
- rd_addr  in  ADDR_W  shadow readback address
- rd_data  out  DATA_W  shadow value for rd_addr, combinational

## Operation

- The FSM has four states: IDLE, SETUP, PULSE and HOLD. A down-counter of width clog2(max cycle param) times each phase.
- IDLE: in_ready=1, busy=0, lat_en=0.
  - On in_valid && in_ready, the controller registers in_addr and in_data.
  - lat_d takes in_data on the same edge.
  - The next state is SETUP with the counter loaded to SETUP_CYC-1.
- SETUP: lat_d is stable and lat_en=0. When the counter reaches 0, the next state is PULSE with the counter loaded to PULSE_CYC-1.
- PULSE: lat_en[addr]=1 and all other bits are 0. When the counter reaches 0, the next state is HOLD with the counter loaded to HOLD_CYC-1. On that same edge, shadow[addr] ← captured data.
- HOLD: lat_en=0 and lat_d is unchanged. done=1 only when the counter is 0. When the counter reaches 0, the next state is IDLE.
- lat_d keeps its last value in IDLE. It changes only on acceptance.
- Registered outputs: lat_d, lat_en, done. Both lat_en and done are decoded into flops, so they are glitch-free.
- Decoded from the state register: in_ready = (state==IDLE) && !rst, and busy = (state!=IDLE).
- Requests are ignored while busy. in_addr and in_data are don't-care outside acceptance.
- Shadow readback:
  - rd_data = shadow[rd_addr].
  - If the shadow update and a read of the same address fall in the same cycle, rd_data shows the old value until the edge.

## Timing

- Reset values while rst is high, applied immediately and asynchronously:
  - state=IDLE
  - lat_en=0
  - lat_d=0
  - done=0
  - busy=0
  - in_ready=0
  - all shadow entries 0
- After rst deasserts, in_ready=1.
- For acceptance at edge E0, the cycle timing is:
  - SETUP occupies cycles E0+1 … E0+SETUP_CYC.
  - The enable is high for exactly PULSE_CYC cycles.
  - HOLD lasts HOLD_CYC cycles.
  - in_ready returns 1 after SETUP_CYC+PULSE_CYC+HOLD_CYC cycles.
- Maximum throughput is one write per SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles. With the defaults, that is 5 cycles per write.
- Reset mid-operation:
  - lat_en drops to 0 asynchronously, so the pulse is truncated.
  - No done pulse is generated.
  - If the shadow update edge had not yet occurred, the shadow is cleared rather than updated.
- Reaching IDLE and accepting a new request never happen in the same cycle. The IDLE cycle between writes is mandatory.
- A constant in_valid=1 produces back-to-back sequences separated by exactly one IDLE cycle.

## Test plan

- Reset then single write: after deassert, send addr=2, data=0xA5 at edge 0. Required response:
  - lat_d=0xA5 from cycle 1.
  - lat_en=4'b0100 during cycles 2–3 and 0 otherwise.
  - done=1 in cycle 4.
  - in_ready=1 in cycle 5.
  - rd_addr=2 → rd_data=0xA5 from cycle 4.
- Back-to-back writes: hold in_valid=1 while sending (0,0x11) then (3,0x3C). Required response:
  - The second acceptance occurs at cycle 5.
  - lat_en=4'b0001 in cycles 2–3 and 4'b1000 in cycles 7–8.
  - Exactly two done pulses, in cycles 4 and 9.
- Request while busy: drive in_valid with (1,0xFF) during cycles 1–4 of the write (2,0xA5). Required response:
  - The request is ignored.
  - lat_d stays 0xA5 throughout.
  - shadow[1] stays 0.
- Reset mid-pulse: assert rst during cycle 2 of a write (2,0xA5). Required response:
  - lat_en=0 immediately.
  - No done pulse.
  - shadow[2]=0.
  - A fresh write after deassert completes normally.
- Parameter sweep: run SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2. Required response:
  - Enable high for exactly 1 cycle, at cycle 4.
  - lat_d stable from cycle 1 to cycle 6.
  - done in cycle 6.
- Overwrite and readback: write 0x5A then 0xC3 to addr 0 and scan rd_addr 0–3. Required response:
  - shadow = {0xC3, 0, 0, 0}.
  - The lat_en bit for addr 0 pulses twice and the others stay 0.
